// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared redirect types: kind encoding (doubles as priority), FSM states, redirect bus layout.
// Kind ordering matters: a pending redirect may only be replaced by an equal or higher kind.
package fetch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        RK_BPU     = 2'd0,
        RK_MISPRED = 2'd1,
        RK_EXC     = 2'd2,
        RK_ERET    = 2'd3
    } rkind_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SQUASH = 2'd2
    } state_e;

    localparam int REDIRECT_BUS_WD = 1 + 2 + 32;

    typedef struct packed {
        logic        vld;
        rkind_e      kind;
        logic [31:0] pc;
    } redirect_bus_t;

    function automatic logic kind_flushes(input rkind_e k);
        return k != RK_BPU;
    endfunction

    function automatic logic kind_squashes(input rkind_e k);
        return (k == RK_EXC) || (k == RK_ERET);
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_prio_sel.sv
// Combinational redirect priority encoder: ERET > exception > mispredict > BPU.
// low_en_i masks mispredict/BPU so a squashed low request cannot mask nothing or win.
module redirect_prio_sel
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_VECTOR = 32'hBFC00380
) (
    input  logic          eret_i,
    input  logic [31:0]   epc_i,
    input  logic          exc_i,
    input  logic          mispred_i,
    input  logic [31:0]   fix_pc_i,
    input  logic          bpu_vld_i,
    input  logic [31:0]   bpu_target_i,
    input  logic          low_en_i,
    output redirect_bus_t win_o
);

    always_comb begin
        win_o = '0;
        if (eret_i) begin
            win_o.vld  = 1'b1;
            win_o.kind = RK_ERET;
            win_o.pc   = epc_i;
        end else if (exc_i) begin
            win_o.vld  = 1'b1;
            win_o.kind = RK_EXC;
            win_o.pc   = EX_VECTOR;
        end else if (low_en_i && mispred_i) begin
            win_o.vld  = 1'b1;
            win_o.kind = RK_MISPRED;
            win_o.pc   = fix_pc_i;
        end else if (low_en_i && bpu_vld_i) begin
            win_o.vld  = 1'b1;
            win_o.kind = RK_BPU;
            win_o.pc   = bpu_target_i;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Pre-IF redirect arbiter: one registered pending slot (latency 1), held until fetch_ready,
// then a squash window after exception/ERET. FETCH_REDIRECT_PERF_EN adds consume counters.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_VECTOR     = 32'hBFC00380,
    parameter int          SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_flush,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_mispredict,
    input  logic [31:0] br_fix_pc,
    input  logic        bpu_valid,
    input  logic [31:0] bpu_target,
    input  logic        fetch_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  redirect_kind,
    output logic        flush_fetch,
    output logic        squash_active,
    output logic [31:0] perf_mispredict,
    output logic [31:0] perf_bpu,
    output logic [31:0] perf_exc
);

    localparam logic [3:0] SQ_INIT = 4'(SQUASH_CYCLES);

    state_e        state_q, state_d;
    redirect_bus_t slot_q, slot_d;
    redirect_bus_t win;
    logic [3:0]    sq_cnt_q, sq_cnt_d;
    logic          flush_q, flush_d;
    logic          consume, squash_consume, low_en, accept;

    assign consume        = slot_q.vld & fetch_ready;
    // An exception/ERET leaving the slot this cycle already opens the wrong-path window.
    assign squash_consume = consume & kind_squashes(slot_q.kind);
    assign low_en         = (state_q != SQUASH) & ~squash_consume;
    assign accept         = win.vld & (~slot_q.vld | consume | (win.kind >= slot_q.kind));

    redirect_prio_sel #(
        .EX_VECTOR (EX_VECTOR)
    ) u_prio_sel (
        .eret_i       (eret),
        .epc_i        (epc),
        .exc_i        (exc_flush),
        .mispred_i    (br_mispredict),
        .fix_pc_i     (br_fix_pc),
        .bpu_vld_i    (bpu_valid),
        .bpu_target_i (bpu_target),
        .low_en_i     (low_en),
        .win_o        (win)
    );

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        sq_cnt_d = sq_cnt_q;
        flush_d  = 1'b0;
        if (consume) begin
            slot_d.vld = 1'b0;
        end
        if (accept) begin
            slot_d   = win;
            flush_d  = kind_flushes(win.kind);
            state_d  = PEND;
            sq_cnt_d = '0;
        end else begin
            case (state_q)
                PEND: begin
                    if (squash_consume) begin
                        state_d  = SQUASH;
                        sq_cnt_d = SQ_INIT;
                    end else if (consume) begin
                        state_d = IDLE;
                    end
                end
                SQUASH: begin
                    if (sq_cnt_q <= 4'd1) begin
                        state_d  = IDLE;
                        sq_cnt_d = '0;
                    end else begin
                        sq_cnt_d = sq_cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            sq_cnt_q <= '0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            sq_cnt_q <= sq_cnt_d;
            flush_q  <= flush_d;
        end
    end

    assign redirect_valid = slot_q.vld;
    assign redirect_pc    = slot_q.pc;
    assign redirect_kind  = slot_q.kind;
    assign flush_fetch    = flush_q;
    assign squash_active  = (state_q == SQUASH);

`ifdef FETCH_REDIRECT_PERF_EN
    logic [31:0] perf_mis_q, perf_bpu_q, perf_exc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_mis_q <= '0;
            perf_bpu_q <= '0;
            perf_exc_q <= '0;
        end else if (consume) begin
            case (slot_q.kind)
                RK_MISPRED: perf_mis_q <= perf_mis_q + 32'd1;
                RK_BPU:     perf_bpu_q <= perf_bpu_q + 32'd1;
                default:    perf_exc_q <= perf_exc_q + 32'd1;
            endcase
        end
    end

    assign perf_mispredict = perf_mis_q;
    assign perf_bpu        = perf_bpu_q;
    assign perf_exc        = perf_exc_q;
`else
    assign perf_mispredict = '0;
    assign perf_bpu        = '0;
    assign perf_exc        = '0;
`endif

    // CP0 must never commit ERET and an exception together; ERET wins if it does.
    eret_exc_exclusive: assert property (@(posedge clk) disable iff (reset) !(eret && exc_flush));

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: inputs change #1 after posedge, outputs checked there.
// obs packs {valid, flush, squash, kind, pc}; ctl is the same without kind/pc.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset, exc_flush, eret, br_mispredict, bpu_valid, fetch_ready;
    logic [31:0] epc, br_fix_pc, bpu_target;
    logic        redirect_valid, flush_fetch, squash_active;
    logic [31:0] redirect_pc, perf_mispredict, perf_bpu, perf_exc;
    logic [1:0]  redirect_kind;
    logic [36:0] obs;
    logic [2:0]  ctl;
    logic [95:0] perf;
    int          checks = 0;
    int          failures = 0;

    assign obs  = {redirect_valid, flush_fetch, squash_active, redirect_kind, redirect_pc};
    assign ctl  = {redirect_valid, flush_fetch, squash_active};
    assign perf = {perf_mispredict, perf_bpu, perf_exc};

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .exc_flush       (exc_flush),
        .eret            (eret),
        .epc             (epc),
        .br_mispredict   (br_mispredict),
        .br_fix_pc       (br_fix_pc),
        .bpu_valid       (bpu_valid),
        .bpu_target      (bpu_target),
        .fetch_ready     (fetch_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_kind   (redirect_kind),
        .flush_fetch     (flush_fetch),
        .squash_active   (squash_active),
        .perf_mispredict (perf_mispredict),
        .perf_bpu        (perf_bpu),
        .perf_exc        (perf_exc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        exc_flush = 1'b0; eret = 1'b0; br_mispredict = 1'b0; bpu_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_ready = 1'b0; clear_req();
        epc = '0; br_fix_pc = '0; bpu_target = '0;
        step(); step();
        checks++; if (obs !== 37'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, 37'h0); end
        checks++; if (perf !== 96'h0) begin failures++; $display("FAIL reset_perf got=%h exp=0", perf); end
        reset = 1'b0;
        step();
        checks++; if (obs !== 37'h0) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, 37'h0); end
    endtask

    task automatic test_bpu();
        fetch_ready = 1'b1; bpu_valid = 1'b1; bpu_target = 32'hBFC00100;
        step(); clear_req();
        checks++; if (obs !== {3'b100, 2'd0, 32'hBFC00100}) begin failures++; $display("FAIL bpu_issue got=%h exp=%h", obs, {3'b100, 2'd0, 32'hBFC00100}); end
        step();
        checks++; if (ctl !== 3'b000) begin failures++; $display("FAIL bpu_consumed got=%b exp=000", ctl); end
    endtask

    task automatic test_overwrite();
        fetch_ready = 1'b0; bpu_valid = 1'b1; bpu_target = 32'h100;
        step(); clear_req();
        checks++; if (obs !== {3'b100, 2'd0, 32'h100}) begin failures++; $display("FAIL ovw_bpu_pend got=%h exp=%h", obs, {3'b100, 2'd0, 32'h100}); end
        br_mispredict = 1'b1; br_fix_pc = 32'h208;
        step(); clear_req(); bpu_valid = 1'b1; bpu_target = 32'h300;
        checks++; if (obs !== {3'b110, 2'd1, 32'h208}) begin failures++; $display("FAIL ovw_mispred got=%h exp=%h", obs, {3'b110, 2'd1, 32'h208}); end
        step(); clear_req();
        checks++; if (obs !== {3'b100, 2'd1, 32'h208}) begin failures++; $display("FAIL ovw_bpu_dropped got=%h exp=%h", obs, {3'b100, 2'd1, 32'h208}); end
        step();
        checks++; if (obs !== {3'b100, 2'd1, 32'h208}) begin failures++; $display("FAIL ovw_held got=%h exp=%h", obs, {3'b100, 2'd1, 32'h208}); end
        fetch_ready = 1'b1;
        step();
        checks++; if (ctl !== 3'b000) begin failures++; $display("FAIL ovw_issued got=%b exp=000", ctl); end
    endtask

    task automatic test_exc_squash();
        fetch_ready = 1'b1; exc_flush = 1'b1; br_mispredict = 1'b1; br_fix_pc = 32'h400;
        step(); clear_req();
        checks++; if (obs !== {3'b110, 2'd2, 32'hBFC00380}) begin failures++; $display("FAIL exc_win got=%h exp=%h", obs, {3'b110, 2'd2, 32'hBFC00380}); end
        step();
        checks++; if (ctl !== 3'b001) begin failures++; $display("FAIL squash_c1 got=%b exp=001", ctl); end
        br_mispredict = 1'b1; br_fix_pc = 32'h500;
        step(); clear_req(); bpu_valid = 1'b1; bpu_target = 32'h600;
        checks++; if (ctl !== 3'b001) begin failures++; $display("FAIL squash_mis_drop got=%b exp=001", ctl); end
        step(); clear_req();
        checks++; if (ctl !== 3'b000) begin failures++; $display("FAIL squash_bpu_drop got=%b exp=000", ctl); end
    endtask

    task automatic test_eret_in_squash();
        fetch_ready = 1'b1; exc_flush = 1'b1;
        step(); clear_req();
        checks++; if (obs !== {3'b110, 2'd2, 32'hBFC00380}) begin failures++; $display("FAIL eret_pre_exc got=%h exp=%h", obs, {3'b110, 2'd2, 32'hBFC00380}); end
        step();
        eret = 1'b1; epc = 32'h80001234; fetch_ready = 1'b0;
        step(); clear_req();
        checks++; if (obs !== {3'b110, 2'd3, 32'h80001234}) begin failures++; $display("FAIL eret_in_squash got=%h exp=%h", obs, {3'b110, 2'd3, 32'h80001234}); end
        fetch_ready = 1'b1;
        step();
        checks++; if (ctl !== 3'b001) begin failures++; $display("FAIL eret_restart1 got=%b exp=001", ctl); end
        step();
        checks++; if (ctl !== 3'b001) begin failures++; $display("FAIL eret_restart2 got=%b exp=001", ctl); end
        step();
        checks++; if (ctl !== 3'b000) begin failures++; $display("FAIL eret_window_end got=%b exp=000", ctl); end
    endtask

    task automatic test_back_to_back();
        fetch_ready = 1'b1; br_mispredict = 1'b1; br_fix_pc = 32'h800;
        step(); clear_req(); bpu_valid = 1'b1; bpu_target = 32'h900;
        checks++; if (obs !== {3'b110, 2'd1, 32'h800}) begin failures++; $display("FAIL b2b_first got=%h exp=%h", obs, {3'b110, 2'd1, 32'h800}); end
        step(); clear_req();
        checks++; if (obs !== {3'b100, 2'd0, 32'h900}) begin failures++; $display("FAIL b2b_second got=%h exp=%h", obs, {3'b100, 2'd0, 32'h900}); end
        step();
        checks++; if (ctl !== 3'b000) begin failures++; $display("FAIL b2b_drain got=%b exp=000", ctl); end
        fetch_ready = 1'b0; br_mispredict = 1'b1; br_fix_pc = 32'hA00;
        step(); br_fix_pc = 32'hA04;
        step(); clear_req();
        checks++; if (obs !== {3'b110, 2'd1, 32'hA04}) begin failures++; $display("FAIL same_kind_overwrite got=%h exp=%h", obs, {3'b110, 2'd1, 32'hA04}); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        step();
        checks++; if (obs !== 37'h0) begin failures++; $display("FAIL reset_mid_pend got=%h exp=%h", obs, 37'h0); end
        reset = 1'b0;
        step();
        checks++; if (ctl !== 3'b000) begin failures++; $display("FAIL reset_mid_pend_after got=%b exp=000", ctl); end
        fetch_ready = 1'b1; exc_flush = 1'b1;
        step(); clear_req();
        step();
        checks++; if (ctl !== 3'b001) begin failures++; $display("FAIL reset_mid_sq_pre got=%b exp=001", ctl); end
        reset = 1'b1;
        step();
        checks++; if (obs !== 37'h0) begin failures++; $display("FAIL reset_mid_squash got=%h exp=%h", obs, 37'h0); end
        checks++; if (perf !== 96'h0) begin failures++; $display("FAIL reset_mid_perf got=%h exp=0", perf); end
        reset = 1'b0;
        step();
        checks++; if (ctl !== 3'b000) begin failures++; $display("FAIL reset_mid_sq_after got=%b exp=000", ctl); end
    endtask

    task automatic test_perf();
        logic [31:0] exp_mis, exp_bpu, exp_exc;
        fetch_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            br_mispredict = 1'b1; br_fix_pc = 32'h1000 + 32'(i * 4);
            step(); clear_req(); step();
        end
        for (int i = 0; i < 2; i++) begin
            bpu_valid = 1'b1; bpu_target = 32'h2000 + 32'(i * 4);
            step(); clear_req(); step();
        end
`ifdef FETCH_REDIRECT_PERF_EN
        exp_mis = 32'd3; exp_bpu = 32'd2; exp_exc = 32'd0;
`else
        exp_mis = 32'd0; exp_bpu = 32'd0; exp_exc = 32'd0;
`endif
        checks++; if (perf_mispredict !== exp_mis) begin failures++; $display("FAIL perf_mispredict got=%0d exp=%0d", perf_mispredict, exp_mis); end
        checks++; if (perf_bpu !== exp_bpu) begin failures++; $display("FAIL perf_bpu got=%0d exp=%0d", perf_bpu, exp_bpu); end
        checks++; if (perf_exc !== exp_exc) begin failures++; $display("FAIL perf_exc got=%0d exp=%0d", perf_exc, exp_exc); end
    endtask

    initial begin
        test_reset();
        test_bpu();
        test_overwrite();
        test_exc_squash();
        test_eret_in_squash();
        test_back_to_back();
        test_reset_mid();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
